// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the alarm controller.
//   alarm_state_t  FSM state encoding (also driven on the State port)
//   bcd_t          one BCD time byte (no digit validation anywhere)
//   DEF_*          default timeouts, in Tick1Hz pulses
//   CNT_W          width of the ring/snooze counter
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZED  = 2'd3
    } alarm_state_t;

    typedef logic [7:0] bcd_t;

    localparam int DEF_RING_TIMEOUT_S = 60;
    localparam int DEF_SNOOZE_S       = 300;
    localparam int CNT_W              = 16;

endpackage

// File: rtl/alarm_match.sv
// alarm_match: compares the stored alarm time against the running clock and
// produces a rising-edge indication of the match.
//   Clk, Reset                  clock and synchronous active-high reset
//   alarm_sec/min/hrs           stored alarm time (BCD bytes)
//   clock_sec/min/hrs           current time (BCD bytes)
//   match                       byte-exact equality of all three fields
//   match_edge                  match high now, low in the previous cycle
module alarm_match
    import alarm_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  bcd_t alarm_sec,
    input  bcd_t alarm_min,
    input  bcd_t alarm_hrs,
    input  bcd_t clock_sec,
    input  bcd_t clock_min,
    input  bcd_t clock_hrs,
    output logic match,
    output logic match_edge
);

    logic match_prev_d;
    logic match_prev_q;

    always_comb begin
        match        = (alarm_sec == clock_sec) &&
                       (alarm_min == clock_min) &&
                       (alarm_hrs == clock_hrs);
        match_prev_d = match;
        match_edge   = match & ~match_prev_q;
    end

    // Resetting the history to 1 means a clock that already equals the
    // (cleared) alarm time right after reset cannot produce a spurious edge.
    always_ff @(posedge Clk) begin
        if (Reset) match_prev_q <= 1'b1;
        else       match_prev_q <= match_prev_d;
    end

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: alarm clock sequencer (arm, ring, snooze, stop).
//   Clk, Reset                      clock, synchronous active-high reset
//   Tick1Hz                         one-cycle pulse per second
//   ClockSeconds/Minutes/Hours      current time, BCD
//   SetAlarm, SetSeconds/...        load request and alarm time to load
//   ArmEn                           level enable; 0 forces DISARMED
//   StopBtn, SnoozeBtn              one-cycle button pulses
//   AlarmSeconds/Minutes/Hours      stored alarm time
//   Buzzer                          high exactly while RINGING
//   State                           registered FSM state
// Build option: define ALARM_SNOOZE_EN to enable the SNOOZED state; without
// it SnoozeBtn is ignored and SNOOZED is never entered.
//
// state     | meaning
// DISARMED  | alarm off, waiting for ArmEn
// ARMED     | waiting for a fresh time match
// RINGING   | buzzer on, counting toward auto-return
// SNOOZED   | buzzer off, counting toward re-ring
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
    parameter int SNOOZE_S       = DEF_SNOOZE_S
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick1Hz,
    input  bcd_t       ClockSeconds,
    input  bcd_t       ClockMinutes,
    input  bcd_t       ClockHours,
    input  logic       SetAlarm,
    input  bcd_t       SetSeconds,
    input  bcd_t       SetMinutes,
    input  bcd_t       SetHours,
    input  logic       ArmEn,
    input  logic       StopBtn,
    input  logic       SnoozeBtn,
    output bcd_t       AlarmSeconds,
    output bcd_t       AlarmMinutes,
    output bcd_t       AlarmHours,
    output logic       Buzzer,
    output logic [1:0] State
);

    localparam logic [CNT_W-1:0] RING_LIMIT   = CNT_W'(RING_TIMEOUT_S);
    localparam logic [CNT_W-1:0] SNOOZE_LIMIT = CNT_W'(SNOOZE_S);

    alarm_state_t     state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q, cnt_inc;
    bcd_t             alarm_sec_d, alarm_sec_q;
    bcd_t             alarm_min_d, alarm_min_q;
    bcd_t             alarm_hrs_d, alarm_hrs_q;
    logic             buzzer_q;
    logic             match;
    logic             match_edge;
    logic             snooze_req;

    alarm_match u_match (
        .Clk        (Clk),
        .Reset      (Reset),
        .alarm_sec  (alarm_sec_q),
        .alarm_min  (alarm_min_q),
        .alarm_hrs  (alarm_hrs_q),
        .clock_sec  (ClockSeconds),
        .clock_min  (ClockMinutes),
        .clock_hrs  (ClockHours),
        .match      (match),
        .match_edge (match_edge)
    );

`ifdef ALARM_SNOOZE_EN
    assign snooze_req = SnoozeBtn;
`else
    logic snooze_unused;
    assign snooze_unused = SnoozeBtn;
    assign snooze_req    = 1'b0;
`endif

    always_comb begin
        // Saturating increment: the counter holds at all-ones, never wraps.
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        alarm_sec_d = alarm_sec_q;
        alarm_min_d = alarm_min_q;
        alarm_hrs_d = alarm_hrs_q;

        if (SetAlarm && (state_q == ST_DISARMED || state_q == ST_ARMED)) begin
            alarm_sec_d = SetSeconds;
            alarm_min_d = SetMinutes;
            alarm_hrs_d = SetHours;
        end

        if (!ArmEn) begin
            state_d = ST_DISARMED;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_DISARMED: begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end
                ST_ARMED: begin
                    cnt_d = '0;
                    if (match_edge) state_d = ST_RINGING;
                end
                ST_RINGING: begin
                    if (StopBtn) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else if (snooze_req) begin
                        state_d = ST_SNOOZED;
                        cnt_d   = '0;
                    end else if (Tick1Hz) begin
                        if (cnt_inc >= RING_LIMIT) begin
                            state_d = ST_ARMED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_SNOOZED: begin
                    if (StopBtn) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else if (Tick1Hz) begin
                        if (cnt_inc >= SNOOZE_LIMIT) begin
                            state_d = ST_RINGING;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_DISARMED;
            cnt_q       <= '0;
            buzzer_q    <= 1'b0;
            alarm_sec_q <= 8'h00;
            alarm_min_q <= 8'h00;
            alarm_hrs_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buzzer_q    <= (state_d == ST_RINGING);
            alarm_sec_q <= alarm_sec_d;
            alarm_min_q <= alarm_min_d;
            alarm_hrs_q <= alarm_hrs_d;
        end
    end

    assign Buzzer       = buzzer_q;
    assign State        = state_q;
    assign AlarmSeconds = alarm_sec_q;
    assign AlarmMinutes = alarm_min_q;
    assign AlarmHours   = alarm_hrs_q;

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed-vector bench for alarm_controller with
// hand-computed expectations. Covers both the default build and the
// ALARM_SNOOZE_EN build.
module tb_alarm_controller;

    localparam logic [1:0] S_DIS  = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RING = 2'd2;
    localparam logic [1:0] S_SNZ  = 2'd3;

    logic       Clk = 1'b0;
    logic       Reset, Tick1Hz, SetAlarm, ArmEn, StopBtn, SnoozeBtn;
    logic [7:0] ClockSeconds, ClockMinutes, ClockHours;
    logic [7:0] SetSeconds, SetMinutes, SetHours;
    logic [7:0] AlarmSeconds, AlarmMinutes, AlarmHours;
    logic       Buzzer;
    logic [1:0] State;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    alarm_controller dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Tick1Hz      (Tick1Hz),
        .ClockSeconds (ClockSeconds),
        .ClockMinutes (ClockMinutes),
        .ClockHours   (ClockHours),
        .SetAlarm     (SetAlarm),
        .SetSeconds   (SetSeconds),
        .SetMinutes   (SetMinutes),
        .SetHours     (SetHours),
        .ArmEn        (ArmEn),
        .StopBtn      (StopBtn),
        .SnoozeBtn    (SnoozeBtn),
        .AlarmSeconds (AlarmSeconds),
        .AlarmMinutes (AlarmMinutes),
        .AlarmHours   (AlarmHours),
        .Buzzer       (Buzzer),
        .State        (State)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_clock(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        ClockHours   = h;
        ClockMinutes = m;
        ClockSeconds = s;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            Tick1Hz = 1'b1;
            step();
            Tick1Hz = 1'b0;
            step();
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input logic bz);
        check({tag, "_state"}, 32'(State), 32'(st));
        check({tag, "_buzzer"}, 32'(Buzzer), 32'(bz));
    endtask

    task automatic check_alarm(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        check({tag, "_hrs"}, 32'(AlarmHours), 32'(h));
        check({tag, "_min"}, 32'(AlarmMinutes), 32'(m));
        check({tag, "_sec"}, 32'(AlarmSeconds), 32'(s));
    endtask

    // Move the clock off and back onto 07:30:00 to create a fresh match.
    task automatic fresh_match();
        set_clock(8'h07, 8'h29, 8'h59);
        step();
        set_clock(8'h07, 8'h30, 8'h00);
        step();
    endtask

    initial begin
        Reset = 1'b1; Tick1Hz = 1'b1; SetAlarm = 1'b1; ArmEn = 1'b1;
        StopBtn = 1'b1; SnoozeBtn = 1'b1;
        SetHours = 8'h12; SetMinutes = 8'h34; SetSeconds = 8'h56;
        set_clock(8'h00, 8'h00, 8'h00);
        step();
        step();
        check_out("reset", S_DIS, 1'b0);
        check_alarm("reset_alarm", 8'h00, 8'h00, 8'h00);

        // Load alarm 07:30:00 while disarmed.
        Reset = 1'b0; Tick1Hz = 1'b0; StopBtn = 1'b0; SnoozeBtn = 1'b0; ArmEn = 1'b0;
        SetAlarm = 1'b0;
        set_clock(8'h07, 8'h29, 8'h59);
        step();
        check_out("idle_disarmed", S_DIS, 1'b0);
        SetAlarm = 1'b1; SetHours = 8'h07; SetMinutes = 8'h30; SetSeconds = 8'h00;
        step();
        SetAlarm = 1'b0;
        check_alarm("load", 8'h07, 8'h30, 8'h00);

        ArmEn = 1'b1;
        step();
        check_out("arm", S_ARM, 1'b0);

        // Partial match (seconds differ) must not ring.
        set_clock(8'h07, 8'h30, 8'h01);
        step();
        check_out("partial_match", S_ARM, 1'b0);

        // Clock reaches 07:30:00: ring one edge later.
        set_clock(8'h07, 8'h30, 8'h00);
        #1;
        check_out("pre_edge", S_ARM, 1'b0);
        step();
        check_out("ring", S_RING, 1'b1);

        // Auto-return after 60 ticks, not 59.
        ticks(59);
        check_out("tick59", S_RING, 1'b1);
        ticks(1);
        check_out("tick60", S_ARM, 1'b0);
        step(); step();
        check_out("no_rering_hold", S_ARM, 1'b0);
        set_clock(8'h07, 8'h30, 8'h05);
        ticks(2);
        check_out("no_rering_xx", S_ARM, 1'b0);

        // Stop and Snooze in the same cycle: Stop wins.
        fresh_match();
        check_out("ring2", S_RING, 1'b1);
        StopBtn = 1'b1; SnoozeBtn = 1'b1;
        step();
        StopBtn = 1'b0; SnoozeBtn = 1'b0;
        check_out("stop_snooze", S_ARM, 1'b0);
        step(); step(); step();
        check_out("stop_no_rering", S_ARM, 1'b0);

        // SetAlarm ignored while ringing, then ArmEn=0 disarms.
        fresh_match();
        check_out("ring3", S_RING, 1'b1);
        SetAlarm = 1'b1; SetHours = 8'h12; SetMinutes = 8'h00; SetSeconds = 8'h00;
        step();
        SetAlarm = 1'b0;
        check_alarm("set_in_ring", 8'h07, 8'h30, 8'h00);
        check_out("ring3_hold", S_RING, 1'b1);
        ArmEn = 1'b0;
        step();
        check_out("disarm", S_DIS, 1'b0);

        // Arming while the clock already matches must not ring.
        ArmEn = 1'b1;
        step();
        check_out("rearm", S_ARM, 1'b0);
        step(); step();
        check_out("arm_while_match", S_ARM, 1'b0);

        // A match edge while ringing must not restart the timeout.
        fresh_match();
        check_out("ring4", S_RING, 1'b1);
        ticks(30);
        fresh_match();
        ticks(29);
        check_out("ring4_t59", S_RING, 1'b1);
        ticks(1);
        check_out("ring4_t60", S_ARM, 1'b0);

        fresh_match();
        check_out("ring5", S_RING, 1'b1);
        SnoozeBtn = 1'b1;
        step();
        SnoozeBtn = 1'b0;
`ifdef ALARM_SNOOZE_EN
        check_out("snooze", S_SNZ, 1'b0);
        ticks(299);
        check_out("snz299", S_SNZ, 1'b0);
        ticks(1);
        check_out("snz300", S_RING, 1'b1);
        SnoozeBtn = 1'b1;
        step();
        SnoozeBtn = 1'b0;
        check_out("snooze2", S_SNZ, 1'b0);
        ticks(5);
`else
        check_out("snooze_ignored", S_RING, 1'b1);
        ticks(3);
        check_out("snooze_ignored_hold", S_RING, 1'b1);
`endif

        // Reset mid-sequence overrides every other input.
        Reset = 1'b1; StopBtn = 1'b1; Tick1Hz = 1'b1;
        step();
        check_out("mid_reset", S_DIS, 1'b0);
        check_alarm("mid_reset_alarm", 8'h00, 8'h00, 8'h00);
        Reset = 1'b0; StopBtn = 1'b0; Tick1Hz = 1'b0;
        step();
        check_out("post_reset", S_ARM, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
